// File: rtl/a2d_spi_resp.sv
`default_nettype none
// ============================================================================
//  Module      : a2d_spi_resp
//  Description : SPI mode-0 responder standing in for the A2D converter.
//                Latches a 16-bit channel-select command from MOSI and
//                returns that channel's reading on MISO during the next
//                frame (one-frame pipelined reply).
//  Revision    : 1.0  initial release
// ============================================================================
module a2d_spi_resp #(
    parameter int NUM_CH = 8,
    parameter int DATA_W = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     SS_n,
    input  logic                     SCLK,
    input  logic                     MOSI,
    input  logic [NUM_CH*DATA_W-1:0] ch_vals,
    output logic                     MISO,
    output logic                     cmd_vld,
    output logic [2:0]               cmd_chnl,
    output logic                     frame_err
);

    localparam logic [0:0] c_ST_IDLE   = 1'b0;
    localparam logic [0:0] c_ST_ACTIVE = 1'b1;
    localparam logic [4:0] c_FRAME_BITS = 5'd16;
    localparam logic [4:0] c_OVER_LEN   = 5'd17;

    // synchronisers; the extra stage on SS_n/SCLK gives the previous value for edge detect
    logic [2:0]  r_ss_sync;
    logic [2:0]  r_sclk_sync;
    logic [1:0]  r_mosi_sync;

    logic [0:0]  r_state;
    logic [0:0]  w_state_nxt;
    logic [15:0] r_tx_shft;
    logic [15:0] r_rx_shft;
    logic [4:0]  r_bit_cnt;
    logic [2:0]  r_cmd_chnl;
    logic        r_cmd_vld;
    logic        r_frame_err;

    logic        w_ss_fall;
    logic        w_ss_rise;
    logic        w_sclk_rise;
    logic        w_sclk_fall;
    logic        w_load;
    logic        w_frame_end;
    logic        w_rx_en;
    logic        w_tx_en;
    logic        w_miso;
    logic [15:0] w_resp;
    logic        w_rx_unused;

    // bring the asynchronous pins into the clk domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ss_sync   <= '0;
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
        end else begin
            r_ss_sync   <= {r_ss_sync[1:0], SS_n};
            r_sclk_sync <= {r_sclk_sync[1:0], SCLK};
            r_mosi_sync <= {r_mosi_sync[0], MOSI};
        end
    end

    assign w_ss_fall   =  r_ss_sync[2]   & ~r_ss_sync[1];
    assign w_ss_rise   = ~r_ss_sync[2]   &  r_ss_sync[1];
    assign w_sclk_rise = ~r_sclk_sync[2] &  r_sclk_sync[1];
    assign w_sclk_fall =  r_sclk_sync[2] & ~r_sclk_sync[1];

    // reply word for the currently latched channel; unmapped channels read as zero
    always_comb begin
        w_resp = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            if (r_cmd_chnl == n[2:0]) begin
                w_resp[DATA_W-1:0] = ch_vals[n*DATA_W +: DATA_W];
            end
        end
    end

    // frame state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // frame state transitions: SS_n edges open and close a frame
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:   if (w_ss_fall) w_state_nxt = c_ST_ACTIVE;
            c_ST_ACTIVE: if (w_ss_rise) w_state_nxt = c_ST_IDLE;
            default:     w_state_nxt = c_ST_IDLE;
        endcase
    end

    // per-state controls; SCLK edges coinciding with the closing SS_n edge are dropped
    always_comb begin
        w_load      = 1'b0;
        w_frame_end = 1'b0;
        w_rx_en     = 1'b0;
        w_tx_en     = 1'b0;
        w_miso      = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_load = w_ss_fall;
            end
            c_ST_ACTIVE: begin
                w_miso      = r_tx_shft[15];
                w_frame_end = w_ss_rise;
                w_rx_en     = w_sclk_rise & ~w_ss_rise;
                w_tx_en     = w_sclk_fall & ~w_ss_rise;
            end
            default: ;
        endcase
    end

    // shift registers and bit counter; the counter parks at 17 to flag over-length
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_shft <= '0;
            r_rx_shft <= '0;
            r_bit_cnt <= '0;
        end else if (w_load) begin
            r_tx_shft <= w_resp;
            r_bit_cnt <= '0;
        end else begin
            if (w_rx_en) begin
                if (r_bit_cnt < c_FRAME_BITS) begin
                    r_rx_shft <= {r_rx_shft[14:0], r_mosi_sync[1]};
                    r_bit_cnt <= r_bit_cnt + 5'd1;
                end else begin
                    r_bit_cnt <= c_OVER_LEN;
                end
            end
            if (w_tx_en) begin
                r_tx_shft <= {r_tx_shft[14:0], 1'b0};
            end
        end
    end

    // end-of-frame verdict: accept exactly 16 bits, otherwise flag the frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmd_chnl  <= '0;
            r_cmd_vld   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_cmd_vld   <= 1'b0;
            r_frame_err <= 1'b0;
            if (w_frame_end) begin
                if (r_bit_cnt == c_FRAME_BITS) begin
                    r_cmd_chnl <= r_rx_shft[13:11];
                    r_cmd_vld  <= 1'b1;
                end else begin
                    r_frame_err <= 1'b1;
                end
            end
        end
    end

    // command bits outside the channel field are don't-care
    assign w_rx_unused = ^{r_rx_shft[15:14], r_rx_shft[10:0]};

    assign MISO      = w_miso;
    assign cmd_vld   = r_cmd_vld;
    assign cmd_chnl  = r_cmd_chnl;
    assign frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_a2d_spi_resp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_a2d_spi_resp
//  Description : Self-checking bench for a2d_spi_resp: directed vector table,
//                mid-frame reset sequence and randomized frames against a
//                frame-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_a2d_spi_resp;

    localparam int NUM_CH = 8;
    localparam int DATA_W = 12;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     SS_n;
    logic                     SCLK;
    logic                     MOSI;
    logic [NUM_CH*DATA_W-1:0] ch_vals;
    logic                     MISO;
    logic                     cmd_vld;
    logic [2:0]               cmd_chnl;
    logic                     frame_err;

    logic [DATA_W-1:0] ch_arr [NUM_CH];

    int checks = 0;
    int errors = 0;
    int n_vld  = 0;
    int n_err  = 0;

    typedef struct {
        logic [15:0] cmd;
        int          nclk;
        int          set_ch;
        logic [11:0] set_val;
        logic [15:0] exp_reply;
        logic [2:0]  exp_chnl;
        int          exp_vld;
        int          exp_err;
    } vec_t;

    vec_t tv [15];

    a2d_spi_resp #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .SS_n      (SS_n),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .ch_vals   (ch_vals),
        .MISO      (MISO),
        .cmd_vld   (cmd_vld),
        .cmd_chnl  (cmd_chnl),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always_comb begin
        ch_vals = '0;
        for (int n = 0; n < NUM_CH; n++) ch_vals[n*DATA_W +: DATA_W] = ch_arr[n];
    end

    // pulse counters, sampled on the falling clk edge
    always @(negedge clk) begin
        if (cmd_vld === 1'b1)   n_vld <= n_vld + 1;
        if (frame_err === 1'b1) n_err <= n_err + 1;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    // one SCLK period: MOSI set mid low phase, MISO sampled just before the rise
    task automatic sclk_bit(input logic b, output logic m);
        #40 MOSI = b;
        #40 m = MISO;
        SCLK = 1'b1;
        #80 SCLK = 1'b0;
    endtask

    task automatic run_frame(input logic [15:0] cmd, input int n, input logic [3:0] extra,
                             output logic [15:0] reply, output logic [3:0] over);
        logic b;
        logic m;
        reply = '0;
        over  = '0;
        SS_n  = 1'b0;
        for (int i = 0; i < n; i++) begin
            b = (i < 16) ? cmd[15-i] : extra[19-i];
            sclk_bit(b, m);
            if (i < 16) reply[15-i] = m;
            else        over[19-i]  = m;
        end
        #80 SS_n = 1'b1;
        #120;
    endtask

    task automatic frame_checks(input string tag, input int n, input logic [15:0] reply,
                                input logic [3:0] over, input logic [15:0] exp_reply,
                                input logic [2:0] exp_chnl, input int dv, input int de,
                                input int exp_dv, input int exp_de);
        logic [15:0] mask;
        mask = 16'hFFFF;
        if (n < 16) mask = mask << (16 - n);
        chk($sformatf("%s reply", tag), {16'h0, reply & mask}, {16'h0, exp_reply & mask});
        if (n > 16) chk($sformatf("%s tail", tag), {28'h0, over}, 32'h0);
        chk($sformatf("%s cmd_vld pulses", tag), dv, exp_dv);
        chk($sformatf("%s frame_err pulses", tag), de, exp_de);
        chk($sformatf("%s cmd_chnl", tag), {29'h0, cmd_chnl}, {29'h0, exp_chnl});
        chk($sformatf("%s idle miso", tag), {31'h0, MISO}, 32'h0);
    endtask

    initial begin
        logic [15:0] reply;
        logic [3:0]  over;
        logic [3:0]  extra;
        logic [15:0] cmd;
        logic [15:0] exp_reply;
        logic [2:0]  exp_next;
        logic        m;
        int          dv0;
        int          de0;
        int          n;
        int          exp_chnl;

        tv[0]  = '{16'h2800, 16,  0, 12'hABC, 16'h0ABC, 3'd5, 1, 0};
        tv[1]  = '{16'h0000, 16,  5, 12'h123, 16'h0123, 3'd0, 1, 0};
        tv[2]  = '{16'h0000, 16, -1, 12'h000, 16'h0ABC, 3'd0, 1, 0};
        tv[3]  = '{16'h0800, 16, -1, 12'h000, 16'h0ABC, 3'd1, 1, 0};
        tv[4]  = '{16'h1000, 16, -1, 12'h000, 16'h022A, 3'd2, 1, 0};
        tv[5]  = '{16'h1800, 16, -1, 12'h000, 16'h033A, 3'd3, 1, 0};
        tv[6]  = '{16'h2000, 16, -1, 12'h000, 16'h044A, 3'd4, 1, 0};
        tv[7]  = '{16'h2800, 16, -1, 12'h000, 16'h055A, 3'd5, 1, 0};
        tv[8]  = '{16'h3000, 16, -1, 12'h000, 16'h0123, 3'd6, 1, 0};
        tv[9]  = '{16'h3800, 16, -1, 12'h000, 16'h077A, 3'd7, 1, 0};
        tv[10] = '{16'h1000,  9, -1, 12'h000, 16'h088A, 3'd7, 0, 1};
        tv[11] = '{16'h0000, 16, -1, 12'h000, 16'h088A, 3'd0, 1, 0};
        tv[12] = '{16'h2000, 20, -1, 12'h000, 16'h0ABC, 3'd0, 0, 1};
        tv[13] = '{16'h1800, 16, -1, 12'h000, 16'h0ABC, 3'd3, 1, 0};
        tv[14] = '{16'h3000, 16, -1, 12'h000, 16'h044A, 3'd6, 1, 0};

        for (int c = 0; c < NUM_CH; c++) ch_arr[c] = {4'(c + 1), 4'(c + 1), 4'hA};
        rst  = 1'b1;
        SS_n = 1'b1;
        SCLK = 1'b0;
        MOSI = 1'b0;
        #30;
        chk("reset MISO", {31'h0, MISO}, 32'h0);
        chk("reset cmd_vld", {31'h0, cmd_vld}, 32'h0);
        chk("reset cmd_chnl", {29'h0, cmd_chnl}, 32'h0);
        chk("reset frame_err", {31'h0, frame_err}, 32'h0);
        #10 rst = 1'b0;
        #100;

        // directed vectors
        for (int i = 0; i < 15; i++) begin
            if (tv[i].set_ch >= 0) ch_arr[tv[i].set_ch] = tv[i].set_val;
            dv0 = n_vld;
            de0 = n_err;
            run_frame(tv[i].cmd, tv[i].nclk, 4'hF, reply, over);
            frame_checks($sformatf("vec%0d", i), tv[i].nclk, reply, over, tv[i].exp_reply,
                         tv[i].exp_chnl, n_vld - dv0, n_err - de0, tv[i].exp_vld, tv[i].exp_err);
            if (tv[i].nclk > 16)
                chk($sformatf("vec%0d rx keeps first 16", i), {16'h0, dut.r_rx_shft}, {16'h0, tv[i].cmd});
        end

        // reset in the middle of a frame replying ch6 (0x077A)
        cmd = 16'h3800;
        dv0 = n_vld;
        de0 = n_err;
        SS_n = 1'b0;
        for (int i = 0; i < 7; i++) sclk_bit(cmd[15-i], m);
        #40 MOSI = cmd[8];
        #40 chk("rst6 miso before reset", {31'h0, MISO}, 32'h1);
        SCLK = 1'b1;
        #10 rst = 1'b1;
        #1;
        chk("rst6 miso in reset", {31'h0, MISO}, 32'h0);
        chk("rst6 cmd_chnl in reset", {29'h0, cmd_chnl}, 32'h0);
        #29 rst = 1'b0;
        #40 SCLK = 1'b0;
        for (int i = 8; i < 16; i++) sclk_bit(cmd[15-i], m);
        #80 SS_n = 1'b1;
        #120;
        chk("rst6 no cmd_vld", n_vld - dv0, 0);
        chk("rst6 no frame_err", n_err - de0, 0);
        chk("rst6 cmd_chnl", {29'h0, cmd_chnl}, 32'h0);
        dv0 = n_vld;
        de0 = n_err;
        run_frame(16'h0000, 16, 4'h0, reply, over);
        frame_checks("rst6 next", 16, reply, over, 16'h0ABC, 3'd0, n_vld - dv0, n_err - de0, 1, 0);

        // randomized frames against a frame-level model
        exp_chnl = 0;
        for (int r = 0; r < 30; r++) begin
            for (int c = 0; c < NUM_CH; c++) ch_arr[c] = 12'($urandom);
            cmd   = 16'($urandom);
            extra = 4'($urandom);
            n     = ($urandom_range(0, 9) < 7) ? 16 : int'($urandom_range(1, 20));
            exp_reply = (exp_chnl < NUM_CH) ? {4'h0, ch_arr[exp_chnl]} : 16'h0000;
            exp_next  = (n == 16) ? cmd[13:11] : 3'(exp_chnl);
            dv0 = n_vld;
            de0 = n_err;
            run_frame(cmd, n, extra, reply, over);
            frame_checks($sformatf("rnd%0d n%0d", r, n), n, reply, over, exp_reply, exp_next,
                         n_vld - dv0, n_err - de0, (n == 16) ? 1 : 0, (n == 16) ? 0 : 1);
            exp_chnl = int'(exp_next);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
